grid_mover: RTL and testbench
=============================

Name: grid_mover

Overview:
Keyboard-driven tile-grid actor controller, the parametrised successor to the fixed top-level direction register in the pacman game. It queues a requested direction and moves the actor one pixel per frame tick. Before entering a tile it checks that tile for walls through a shared tile-RAM port. On reaching a pellet tile it clears the tile and increments a score. It sits between the keyboard, the frame timing and the RAM arbiter, and feeds the sprite renderer's position and direction inputs.

Parameters:
COLS_LOG2, 5, log2 of grid columns; column index wraps modulo 2^COLS_LOG2
ROWS_LOG2, 5, log2 of grid rows; row index wraps modulo 2^ROWS_LOG2
TILE_PX_LOG2, 4, log2 of pixels per tile
START_COL, 1, reset tile column
START_ROW, 1, reset tile row
START_DIR, 1, reset direction (0 up, 1 right, 2 down, 3 left)
KEY_UP, 8'hf7, keycode for up
KEY_RIGHT, 8'he1, keycode for right
KEY_DOWN, 8'hf3, keycode for down
KEY_LEFT, 8'he4, keycode for left
PELLET_TYPE, 2'd3, tile[1:0] value meaning pellet; 0 means empty; any other value is wall

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle frame pulse; one movement step per tick
keycode  in  8  keyboard code; bit 7 set means a key is pending
keystrobe  out  1  one-cycle acknowledge of a consumed key
mem_req  out  1  tile-RAM access request
mem_addr  out  ROWS_LOG2+COLS_LOG2  tile address {row,col}
mem_we  out  1  write qualifier, valid while mem_req is high
mem_wdata  out  8  write data (always 8'h00, clears a pellet)
mem_grant  in  1  arbiter grant; the access occurs on this cycle
mem_rdata  in  8  read data, valid the cycle after grant
pos_x  out  COLS_LOG2+TILE_PX_LOG2  actor pixel X
pos_y  out  ROWS_LOG2+TILE_PX_LOG2  actor pixel Y
dir  out  2  current direction
moving  out  1  high if the last tick produced a step
score  out  16  count of eaten pellets, saturating at 16'hFFFF
pellet_eaten  out  1  one-cycle pulse per eaten pellet

Behaviour:
- Reset values:
  - pos = {START_COL/ROW, TILE_PX_LOG2'b0}
  - dir and want = START_DIR
  - score 0, moving 0
  - keystrobe, mem_req, mem_we, pellet_eaten all 0
  - FSM in IDLE
- Reset mid-access: mem_req drops immediately; no write may complete.
- Key intake, in any state:
  - If keycode[7] is high and keystrobe was low in the previous cycle, pulse keystrobe for one cycle.
  - If keycode matches a KEY_* parameter, set want to that direction; unmatched codes are acknowledged and ignored.
- Aligned means the low TILE_PX_LOG2 bits of both pos_x and pos_y are 0.
- FSM states: IDLE, RD_WANT, RD_CUR, STEP, RD_HERE, WR_HERE.
  - IDLE: on tick, go to RD_WANT if aligned. If not aligned:
    - want == dir^2 (reversal): set dir = want.
    - Go to STEP.
  - RD_WANT: if want == dir, skip to RD_CUR. Otherwise request the neighbour tile in direction want.
    - One cycle after grant, sample mem_rdata[1:0].
    - If passable (0 or PELLET_TYPE), set dir = want.
    - Go to RD_CUR.
  - RD_CUR: request the neighbour tile in dir and sample it the same way.
    - Passable: go to STEP.
    - Wall: moving = 0, go to IDLE.
  - STEP: add or subtract 1 pixel on the dir axis, modulo the full pixel range (tunnel wrap); moving = 1.
    - If the new position is aligned, go to RD_HERE; else go to IDLE.
  - RD_HERE: read the current tile.
    - If tile[1:0] == PELLET_TYPE, go to WR_HERE; else go to IDLE.
  - WR_HERE: hold mem_req = 1, mem_we = 1, mem_wdata = 0 until grant.
    - On the grant cycle the write occurs.
    - Next cycle: deassert, pulse pellet_eaten, score++ (saturating), go to IDLE.
- Handshake:
  - mem_req and mem_addr stay stable until mem_grant is sampled high.
  - mem_req drops the cycle after grant.
  - A grant while mem_req is low is ignored.
- Neighbour address: row/col ±1, wrapping modulo the grid.
- Ticks arriving outside IDLE are dropped; the worst-case pass is 4 accesses, which fits within one frame.
- Simultaneous key and tick: the key update is visible to the decision made on that tick.

Decomposition:
- Shared package:
  - direction encoding constants DIR_UP/RIGHT/DOWN/LEFT
  - tile type constants TILE_EMPTY, TILE_PELLET
  - FSM state encoding
- Sub-module grid_neighbor (combinational): {row, col, dir} -> wrapped neighbour {row, col}; instantiated once, with its dir input muxed between want and dir.

Test Plan:
- Reset: hold reset=0 then release -> pos_x = 16, pos_y = 16, dir = 1, score = 0, mem_req = 0, keystrobe = 0.
- Open corridor, 16 ticks right -> pos_x = 32, one RD_CUR access per aligned tick, moving = 1.
- Wall at {1,2}, 3 ticks -> pos_x stays 16, moving = 0, no STEP.
- Queued turn: keycode = 8'hf3 at pos_x = 20 with {2,1} open -> keystrobe pulses once; dir becomes 2 at pos_x = 32 only if {2,2} open; otherwise continues right.
- Pellet: tile {1,2} = 8'h03, 16 ticks -> write of 8'h00 to address {5'd1,5'd2}, pellet_eaten pulses once, score = 1.
- Tunnel and arbitration:
  - Start col 31 with dir right, 16 ticks -> pos_x wraps to 0.
  - mem_grant delayed 5 cycles -> mem_addr is stable throughout and exactly one access completes.

Source files
------------

// File: rtl/grid_mover_pkg.sv
// grid_mover_pkg
//   Shared encodings for the tile-grid actor controller: direction codes,
//   tile type codes, the controller state encoding and a small direction
//   helper.
package grid_mover_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [1:0] TILE_EMPTY  = 2'd0;
  localparam logic [1:0] TILE_PELLET = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WANT,
    ST_RD_CUR,
    ST_STEP,
    ST_RD_HERE,
    ST_WR_HERE
  } state_t;

  // Opposite direction: the encoding places opposites two apart.
  function automatic logic [1:0] reverse_dir(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/grid_mover_if.sv
// grid_mover_if
//   Tile-RAM access port between the actor controller and the RAM arbiter.
//   master: controller side (drives request, address, write qualifier/data)
//   slave : arbiter side (drives grant and read data)
//   mem_req   request, held with mem_addr stable until mem_grant is seen
//   mem_addr  tile address {row, col}
//   mem_we    write qualifier, meaningful while mem_req is high
//   mem_wdata write data
//   mem_grant access happens on the cycle this is high
//   mem_rdata read data, valid the cycle after the grant
interface grid_mover_if #(
  parameter int ADDR_W = 10
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              mem_grant;
  logic [7:0]        mem_rdata;

  modport master (
    output mem_req, mem_addr, mem_we, mem_wdata,
    input  mem_grant, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr, mem_we, mem_wdata,
    output mem_grant, mem_rdata
  );
endinterface

// File: rtl/grid_neighbor.sv
// grid_neighbor
//   Combinational neighbour-tile lookup. Returns the tile one step away from
//   {row, col} in direction dir; both indices wrap modulo the grid size so the
//   edges behave as tunnels.
//   row, col        current tile
//   dir             direction to look in
//   nb_row, nb_col  neighbouring tile
module grid_neighbor
  import grid_mover_pkg::*;
#(
  parameter int COLS_LOG2 = 5,
  parameter int ROWS_LOG2 = 5
) (
  input  logic [ROWS_LOG2-1:0] row,
  input  logic [COLS_LOG2-1:0] col,
  input  logic [1:0]           dir,
  output logic [ROWS_LOG2-1:0] nb_row,
  output logic [COLS_LOG2-1:0] nb_col
);

  always_comb begin
    nb_row = row;
    nb_col = col;
    case (dir)
      DIR_UP:    nb_row = row - ROWS_LOG2'(1);
      DIR_RIGHT: nb_col = col + COLS_LOG2'(1);
      DIR_DOWN:  nb_row = row + ROWS_LOG2'(1);
      default:   nb_col = col - COLS_LOG2'(1);
    endcase
  end

endmodule

// File: rtl/grid_mover.sv
// grid_mover
//   Keyboard-driven actor controller for a tile grid. Queues a requested
//   direction, moves one pixel per frame tick, checks the tile ahead for
//   walls through the shared tile-RAM port and eats pellets on arrival.
//   clk, reset     system clock, asynchronous active-low reset
//   tick           one-cycle frame pulse, one movement step per tick
//   keycode        keyboard code, bit 7 marks a pending key
//   keystrobe      one-cycle acknowledge of a consumed key
//   mem            tile-RAM master port
//   pos_x, pos_y   actor pixel position
//   dir            current direction
//   moving         last tick produced a step
//   score          eaten pellets, saturating
//   pellet_eaten   one-cycle pulse per eaten pellet
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for a tick
//   ST_RD_WANT | reading neighbour in the queued direction (turn check)
//   ST_RD_CUR  | reading neighbour in the current direction (wall check)
//   ST_STEP    | moving one pixel along dir
//   ST_RD_HERE | reading the tile just entered
//   ST_WR_HERE | clearing the pellet on the tile just entered
module grid_mover
  import grid_mover_pkg::*;
#(
  parameter int         COLS_LOG2    = 5,
  parameter int         ROWS_LOG2    = 5,
  parameter int         TILE_PX_LOG2 = 4,
  parameter int         START_COL    = 1,
  parameter int         START_ROW    = 1,
  parameter logic [1:0] START_DIR    = 2'd1,
  parameter logic [7:0] KEY_UP       = 8'hf7,
  parameter logic [7:0] KEY_RIGHT    = 8'he1,
  parameter logic [7:0] KEY_DOWN     = 8'hf3,
  parameter logic [7:0] KEY_LEFT     = 8'he4,
  parameter logic [1:0] PELLET_TYPE  = TILE_PELLET
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tick,
  input  logic [7:0]                        keycode,
  output logic                              keystrobe,
  grid_mover_if.master                      mem,
  output logic [COLS_LOG2+TILE_PX_LOG2-1:0] pos_x,
  output logic [ROWS_LOG2+TILE_PX_LOG2-1:0] pos_y,
  output logic [1:0]                        dir,
  output logic                              moving,
  output logic [15:0]                       score,
  output logic                              pellet_eaten
);

  localparam int PX_W = COLS_LOG2 + TILE_PX_LOG2;
  localparam int PY_W = ROWS_LOG2 + TILE_PX_LOG2;

  state_t            state, state_nx;
  logic              data_ph, data_ph_nx;
  logic [1:0]        want, want_nx;
  logic [1:0]        dir_nx;
  logic [1:0]        try_dir, try_dir_nx;
  logic [PX_W-1:0]   pos_x_nx;
  logic [PY_W-1:0]   pos_y_nx;
  logic              moving_nx;
  logic [15:0]       score_nx;
  logic              pellet_nx;

  logic              key_take;
  logic [1:0]        key_dir;
  logic [1:0]        want_eff;
  logic              aligned;
  logic [1:0]        nb_dir;
  logic [ROWS_LOG2-1:0] cur_row, nb_row;
  logic [COLS_LOG2-1:0] cur_col, nb_col;
  logic [1:0]        tile_type;
  logic              tile_ok;

  function automatic logic passable(input logic [1:0] t);
    return (t == TILE_EMPTY) || (t == PELLET_TYPE);
  endfunction

  // A key taken this cycle is folded into want_eff so a tick arriving in the
  // same cycle already decides with the new direction.
  always_comb begin
    key_take = keycode[7] && !keystrobe;
    key_dir  = want;
    if (keycode == KEY_UP)         key_dir = DIR_UP;
    else if (keycode == KEY_RIGHT) key_dir = DIR_RIGHT;
    else if (keycode == KEY_DOWN)  key_dir = DIR_DOWN;
    else if (keycode == KEY_LEFT)  key_dir = DIR_LEFT;
    want_eff = key_take ? key_dir : want;
  end

  assign cur_col   = pos_x[PX_W-1:TILE_PX_LOG2];
  assign cur_row   = pos_y[PY_W-1:TILE_PX_LOG2];
  assign aligned   = (pos_x[TILE_PX_LOG2-1:0] == '0) && (pos_y[TILE_PX_LOG2-1:0] == '0);
  assign tile_type = mem.mem_rdata[1:0];
  assign tile_ok   = passable(tile_type);

  // try_dir is latched when the turn check starts, so a key arriving while
  // the request is pending cannot disturb mem_addr.
  assign nb_dir = (state == ST_RD_WANT) ? try_dir : dir;

  grid_neighbor #(
    .COLS_LOG2 (COLS_LOG2),
    .ROWS_LOG2 (ROWS_LOG2)
  ) u_neighbor (
    .row    (cur_row),
    .col    (cur_col),
    .dir    (nb_dir),
    .nb_row (nb_row),
    .nb_col (nb_col)
  );

  // Request is decoded from state so an asynchronous reset drops it at once.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_wdata = 8'h00;
    mem.mem_addr  = {cur_row, cur_col};
    case (state)
      ST_RD_WANT: begin
        mem.mem_addr = {nb_row, nb_col};
        mem.mem_req  = !data_ph && (try_dir != dir);
      end
      ST_RD_CUR: begin
        mem.mem_addr = {nb_row, nb_col};
        mem.mem_req  = !data_ph;
      end
      ST_RD_HERE: mem.mem_req = !data_ph;
      ST_WR_HERE: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx   = state;
    data_ph_nx = data_ph;
    want_nx    = want_eff;
    dir_nx     = dir;
    try_dir_nx = try_dir;
    pos_x_nx   = pos_x;
    pos_y_nx   = pos_y;
    moving_nx  = moving;
    score_nx   = score;
    pellet_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          if (aligned) begin
            try_dir_nx = want_eff;
            state_nx   = ST_RD_WANT;
          end else begin
            if (want_eff == reverse_dir(dir)) dir_nx = want_eff;
            state_nx = ST_STEP;
          end
        end
      end
      ST_RD_WANT: begin
        if (try_dir == dir) begin
          state_nx = ST_RD_CUR;
        end else if (!data_ph) begin
          if (mem.mem_grant) data_ph_nx = 1'b1;
        end else begin
          data_ph_nx = 1'b0;
          if (tile_ok) dir_nx = try_dir;
          state_nx = ST_RD_CUR;
        end
      end
      ST_RD_CUR: begin
        if (!data_ph) begin
          if (mem.mem_grant) data_ph_nx = 1'b1;
        end else begin
          data_ph_nx = 1'b0;
          if (tile_ok) begin
            state_nx = ST_STEP;
          end else begin
            moving_nx = 1'b0;
            state_nx  = ST_IDLE;
          end
        end
      end
      ST_STEP: begin
        moving_nx = 1'b1;
        case (dir)
          DIR_UP:    pos_y_nx = pos_y - PY_W'(1);
          DIR_RIGHT: pos_x_nx = pos_x + PX_W'(1);
          DIR_DOWN:  pos_y_nx = pos_y + PY_W'(1);
          default:   pos_x_nx = pos_x - PX_W'(1);
        endcase
        if ((pos_x_nx[TILE_PX_LOG2-1:0] == '0) && (pos_y_nx[TILE_PX_LOG2-1:0] == '0))
          state_nx = ST_RD_HERE;
        else
          state_nx = ST_IDLE;
      end
      ST_RD_HERE: begin
        if (!data_ph) begin
          if (mem.mem_grant) data_ph_nx = 1'b1;
        end else begin
          data_ph_nx = 1'b0;
          state_nx   = (tile_type == PELLET_TYPE) ? ST_WR_HERE : ST_IDLE;
        end
      end
      ST_WR_HERE: begin
        if (mem.mem_grant) begin
          pellet_nx = 1'b1;
          if (score != 16'hFFFF) score_nx = score + 16'd1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      data_ph      <= 1'b0;
      want         <= START_DIR;
      dir          <= START_DIR;
      try_dir      <= START_DIR;
      pos_x        <= {COLS_LOG2'(START_COL), {TILE_PX_LOG2{1'b0}}};
      pos_y        <= {ROWS_LOG2'(START_ROW), {TILE_PX_LOG2{1'b0}}};
      moving       <= 1'b0;
      score        <= 16'd0;
      pellet_eaten <= 1'b0;
      keystrobe    <= 1'b0;
    end else begin
      state        <= state_nx;
      data_ph      <= data_ph_nx;
      want         <= want_nx;
      dir          <= dir_nx;
      try_dir      <= try_dir_nx;
      pos_x        <= pos_x_nx;
      pos_y        <= pos_y_nx;
      moving       <= moving_nx;
      score        <= score_nx;
      pellet_eaten <= pellet_nx;
      keystrobe    <= key_take;
    end
  end

endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover
//   Directed bench for grid_mover: a tile-RAM/arbiter responder with
//   programmable grant delay, and a linear sequence of moves with
//   hand-computed positions, directions, access counts and pellet results.
module tb_grid_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       keystrobe, moving, pellet_eaten;
  logic [1:0] dir;
  logic [8:0] pos_x, pos_y;
  logic [15:0] score;

  grid_mover_if #(.ADDR_W(10)) mem_bus ();

  grid_mover dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .keycode      (keycode),
    .keystrobe    (keystrobe),
    .mem          (mem_bus),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .dir          (dir),
    .moving       (moving),
    .score        (score),
    .pellet_eaten (pellet_eaten)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] ram [0:1023];
  int   grant_delay = 0;
  logic block_writes = 1'b0;
  int   wait_cnt = 0;
  int   accesses = 0;
  int   writes = 0;
  int   addr_changes = 0;
  int   req_after_grant = 0;
  int   ks_cnt = 0;
  int   pe_cnt = 0;
  logic in_req = 1'b0;
  logic prev_gnt = 1'b0;
  logic gwe = 1'b0;
  logic [9:0] req_addr = '0;
  logic [9:0] gaddr = '0;
  logic [9:0] wr_addr = '0;
  logic [7:0] gwdata = '0;
  logic [7:0] wr_data = 8'hff;

  // RAM + arbiter responder; grant is decided on the falling edge and held
  // through the next rising edge, read data follows one cycle later.
  initial begin
    mem_bus.mem_grant = 1'b0;
    mem_bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (keystrobe === 1'b1) ks_cnt++;
      if (pellet_eaten === 1'b1) pe_cnt++;
      if (!reset) begin
        mem_bus.mem_grant = 1'b0;
        prev_gnt = 1'b0;
        in_req = 1'b0;
      end else begin
        if (prev_gnt) begin
          if (mem_bus.mem_req) req_after_grant++;
          if (gwe) begin
            ram[gaddr] = gwdata;
            writes++;
            wr_addr = gaddr;
            wr_data = gwdata;
          end else begin
            mem_bus.mem_rdata = ram[gaddr];
          end
        end
        prev_gnt = 1'b0;
        if (mem_bus.mem_req) begin
          if (!in_req) begin
            in_req = 1'b1;
            req_addr = mem_bus.mem_addr;
            wait_cnt = 0;
          end else if (mem_bus.mem_addr !== req_addr) begin
            addr_changes++;
          end
          if (mem_bus.mem_we && block_writes) begin
            mem_bus.mem_grant = 1'b0;
          end else if (wait_cnt >= grant_delay) begin
            mem_bus.mem_grant = 1'b1;
            prev_gnt = 1'b1;
            gaddr = mem_bus.mem_addr;
            gwe = mem_bus.mem_we;
            gwdata = mem_bus.mem_wdata;
            in_req = 1'b0;
            accesses++;
          end else begin
            mem_bus.mem_grant = 1'b0;
            wait_cnt++;
          end
        end else begin
          mem_bus.mem_grant = 1'b0;
          in_req = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic press(input logic [7:0] code);
    @(negedge clk);
    keycode = code;
    @(negedge clk);
    keycode = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  int a0, ks0, pe0, w0, ac0;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_pos_x", 32'(pos_x), 16);
    check("rst_pos_y", 32'(pos_y), 16);
    check("rst_dir", 32'(dir), 1);
    check("rst_score", 32'(score), 0);
    check("rst_mem_req", 32'(mem_bus.mem_req), 0);
    check("rst_keystrobe", 32'(keystrobe), 0);
    check("rst_moving", 32'(moving), 0);

    // wall at {1,2}: three ticks, no step
    ram[34] = 8'h01;
    a0 = accesses;
    ticks(3, 20);
    check("wall_pos_x", 32'(pos_x), 16);
    check("wall_moving", 32'(moving), 0);
    check("wall_accesses", 32'(accesses - a0), 3);

    // open corridor with a down key queued at pos_x 20; {2,2} is a wall
    ram[34] = 8'h00;
    ram[66] = 8'h01;
    a0 = accesses;
    ks0 = ks_cnt;
    ticks(4, 20);
    check("corr_pos_x20", 32'(pos_x), 20);
    press(8'hf3);
    check("key_down_strobe", 32'(ks_cnt - ks0), 1);
    check("key_down_dir_kept", 32'(dir), 1);
    ticks(12, 20);
    check("corr_pos_x32", 32'(pos_x), 32);
    check("corr_moving", 32'(moving), 1);
    check("corr_accesses", 32'(accesses - a0), 2);
    ticks(1, 20);
    check("turn_blocked_dir", 32'(dir), 1);
    check("turn_blocked_x", 32'(pos_x), 33);
    ticks(15, 20);
    check("corr_pos_x48", 32'(pos_x), 48);
    ticks(1, 20);
    check("turn_ok_dir", 32'(dir), 2);
    check("turn_ok_y", 32'(pos_y), 17);
    check("turn_ok_x", 32'(pos_x), 48);

    // unmatched key acknowledged and ignored
    ks0 = ks_cnt;
    press(8'h9a);
    check("key_bad_strobe", 32'(ks_cnt - ks0), 1);
    ticks(1, 20);
    check("key_bad_y", 32'(pos_y), 18);
    check("key_bad_dir", 32'(dir), 2);

    // reversal between tiles takes effect immediately
    press(8'hf7);
    ticks(1, 20);
    check("rev_dir", 32'(dir), 0);
    check("rev_y", 32'(pos_y), 17);
    ticks(1, 20);
    check("rev_y_aligned", 32'(pos_y), 16);

    // pellet at {1,2}: turn left, 16 ticks, eat it
    ram[34] = 8'h03;
    pe0 = pe_cnt;
    w0 = writes;
    press(8'he4);
    ticks(16, 20);
    check("pel_pos_x", 32'(pos_x), 32);
    check("pel_dir", 32'(dir), 3);
    check("pel_writes", 32'(writes - w0), 1);
    check("pel_wr_addr", 32'(wr_addr), 34);
    check("pel_wr_data", 32'(wr_data), 0);
    check("pel_ram_cleared", 32'(ram[34]), 0);
    check("pel_pulses", 32'(pe_cnt - pe0), 1);
    check("pel_score", 32'(score), 1);

    // tunnel leftwards past column 0
    ticks(33, 20);
    check("tun_left_x", 32'(pos_x), 511);
    ticks(15, 20);
    check("tun_col31_x", 32'(pos_x), 496);

    // tunnel rightwards from column 31
    press(8'he1);
    ticks(16, 20);
    check("tun_right_x", 32'(pos_x), 0);
    check("tun_right_dir", 32'(dir), 1);
    check("tun_right_y", 32'(pos_y), 16);
    check("tun_score", 32'(score), 1);

    // delayed grant: address stable, one access
    grant_delay = 5;
    a0 = accesses;
    ac0 = addr_changes;
    ticks(1, 40);
    check("arb_accesses", 32'(accesses - a0), 1);
    check("arb_addr_stable", 32'(addr_changes - ac0), 0);
    check("arb_gaddr", 32'(gaddr), 33);
    check("arb_pos_x", 32'(pos_x), 1);
    ticks(15, 20);
    check("arb_pos_x16", 32'(pos_x), 16);

    // reset while the pellet write is waiting for grant
    ram[34] = 8'h03;
    grant_delay = 0;
    block_writes = 1'b1;
    w0 = writes;
    pe0 = pe_cnt;
    ticks(16, 20);
    check("mid_req_high", 32'(mem_bus.mem_req), 1);
    check("mid_we_high", 32'(mem_bus.mem_we), 1);
    check("mid_addr", 32'(mem_bus.mem_addr), 34);
    reset = 1'b0;
    #1;
    check("mid_req_dropped", 32'(mem_bus.mem_req), 0);
    check("mid_we_dropped", 32'(mem_bus.mem_we), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    block_writes = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_no_write", 32'(writes - w0), 0);
    check("mid_ram_kept", 32'(ram[34]), 3);
    check("mid_no_pellet", 32'(pe_cnt - pe0), 0);
    check("mid_score", 32'(score), 0);
    check("mid_pos_x", 32'(pos_x), 16);
    check("mid_pos_y", 32'(pos_y), 16);
    check("mid_dir", 32'(dir), 1);
    check("mid_req_idle", 32'(mem_bus.mem_req), 0);

    // handshake rules over the whole run
    check("req_drops_after_grant", 32'(req_after_grant), 0);
    check("addr_stable_total", 32'(addr_changes), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
